alu_exec_unit: RTL

//  Execute-stage ALU that sits directly downstream of decoder_alu. Consumes its
//  3-bit ALU control and 1-bit funct control plus two WIDTH-bit operands.

---
 rtl/alu_exec_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Execute-stage ALU with valid/ready handshake; bit-serial shifts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_exec_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             in_clk,
   input  logic             in_rst,
   input  logic             in_valid,
   output logic             out_ready,
   input  logic [2:0]       in_alu_control,
   input  logic             in_funct_control,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             in_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [2:0] c_op_add_sub = 3'b000;
   localparam logic [2:0] c_op_sll     = 3'b001;
   localparam logic [2:0] c_op_slt     = 3'b010;
   localparam logic [2:0] c_op_sltu    = 3'b011;
   localparam logic [2:0] c_op_xor     = 3'b100;
   localparam logic [2:0] c_op_srl_sra = 3'b101;
   localparam logic [2:0] c_op_or      = 3'b110;
   localparam logic [2:0] c_op_and     = 3'b111;

   state_t               r_state;
   logic [WIDTH-1:0]     r_acc;
   logic [SHAMT_W-1:0]   r_cnt;
   logic                 r_shift_left;
   logic                 r_arith;
   logic [WIDTH-1:0]     r_result;
   logic                 r_zero;

   logic [WIDTH-1:0]     w_alu;
   logic [WIDTH-1:0]     w_acc_next;
   logic [SHAMT_W-1:0]   w_shamt;
   logic                 w_is_shift;
   logic                 w_accept;

   assign w_shamt    = in_b[SHAMT_W-1:0];
   assign w_is_shift = (in_alu_control == c_op_sll) || (in_alu_control == c_op_srl_sra);
   assign w_accept   = in_valid && (r_state == S_IDLE);

   // Shift ops fall through to in_a so a zero shift amount completes in one cycle.
   always_comb begin
      w_alu = in_a;
      case (in_alu_control)
         c_op_add_sub: w_alu = in_funct_control ? (in_a - in_b) : (in_a + in_b);
         c_op_slt:     w_alu = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
         c_op_sltu:    w_alu = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
         c_op_xor:     w_alu = in_a ^ in_b;
         c_op_or:      w_alu = in_a | in_b;
         c_op_and:     w_alu = in_a & in_b;
         default:      w_alu = in_a;
      endcase
   end

   always_comb begin
      w_acc_next = r_acc;
      if (r_shift_left) begin
         w_acc_next = {r_acc[WIDTH-2:0], 1'b0};
      end else begin
         w_acc_next = {(r_arith & r_acc[WIDTH-1]), r_acc[WIDTH-1:1]};
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_state      <= S_IDLE;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_shift_left <= 1'b0;
         r_arith      <= 1'b0;
         r_result     <= '0;
         r_zero       <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_shift_left <= (in_alu_control == c_op_sll);
                  r_arith      <= in_funct_control;
                  if (w_is_shift && (w_shamt != '0)) begin
                     r_acc   <= in_a;
                     r_cnt   <= w_shamt;
                     r_state <= S_SHIFT;
                  end else begin
                     r_result <= w_alu;
                     r_zero   <= (w_alu == '0);
                     r_state  <= S_DONE;
                  end
               end
            end
            S_SHIFT: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                  r_result <= w_acc_next;
                  r_zero   <= (w_acc_next == '0);
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               if (in_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out_ready  = (r_state == S_IDLE);
   assign out_valid  = (r_state == S_DONE);
   assign out_result = r_result;
   assign out_zero   = r_zero;

endmodule

`default_nettype wire
